// File: rtl/tens_comp_seq_if.sv
// Operand/result bundle for tens_comp_seq: requester drives start/sub/a/b, the adder returns
// busy/done/result/ovf/err.
interface tens_comp_seq_if;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        err;

  modport master (output start, sub, a, b, input busy, done, result, ovf, err);
  modport slave  (input start, sub, a, b, output busy, done, result, ovf, err);
endinterface

// File: rtl/tens_comp_seq.sv
// 4-digit BCD ten's-complement add/subtract using one digit adder, LSD first, 5-cycle latency.
// Optional operand digit check enabled by defining TENS_COMP_BCD_CHECK_EN.
module tens_comp_seq (
  input logic            clk,
  input logic            clr,
  tens_comp_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic        sub_q, sub_d;
  logic [15:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        ovf_q, ovf_d, err_q, err_d;

  logic [3:0]  dig_a, dig_b, dig_bp, dig_sum;
  logic [4:0]  dig_raw;
  logic        dig_c, dig_co;
  logic        a_neg, b_neg, r_neg, ovf_calc;
  logic        bad_digit;

  // The single shared digit adder; carry-in of the LSD is the latched sub (ten's complement +1).
  assign dig_a   = a_q[{cnt_q, 2'b00} +: 4];
  assign dig_b   = b_q[{cnt_q, 2'b00} +: 4];
  assign dig_bp  = sub_q ? (4'd9 - dig_b) : dig_b;
  assign dig_c   = (cnt_q == 2'd0) ? sub_q : carry_q;
  assign dig_raw = {1'b0, dig_a} + {1'b0, dig_bp} + {4'b0000, dig_c};
  assign dig_co  = (dig_raw > 5'd9);
  assign dig_sum = dig_co ? (dig_raw[3:0] - 4'd10) : dig_raw[3:0];

  // Only meaningful while the MSD is in the adder (cnt_q == 3).
  assign a_neg    = (a_q[15:12] >= 4'd5);
  assign b_neg    = (b_q[15:12] >= 4'd5);
  assign r_neg    = (dig_sum >= 4'd5);
  assign ovf_calc = sub_q ? ((!a_neg && b_neg && r_neg) || (a_neg && !b_neg && !r_neg))
                          : ((!a_neg && !b_neg && r_neg) || (a_neg && b_neg && !r_neg));

`ifdef TENS_COMP_BCD_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          carry_d = 1'b0;
          cnt_d   = 2'd0;
          res_d   = 16'h0000;
          ovf_d   = 1'b0;
          err_d   = bad_digit;
          state_d = bad_digit ? StDone : StAdd;
        end
      end
      StAdd: begin
        res_d[{cnt_q, 2'b00} +: 4] = dig_sum;
        carry_d = dig_co;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          ovf_d   = ovf_calc;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      res_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy   = (state_q == StAdd);
  assign bus.done   = (state_q == StDone);
  assign bus.result = res_q;
  assign bus.ovf    = ovf_q;
  assign bus.err    = err_q;

endmodule
